// File: rtl/ddmtd_edge_tagger.sv
// ddmtd_edge_tagger: deglitches a synchronized DDMTD beat and timestamps each confirmed edge
// onto a single-entry AXI-Stream output register.
module ddmtd_edge_tagger #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEGLITCH_LEN = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_ref,
  input  logic                  RESETN,
  input  logic                  enable_sampling_logic,
  input  logic                  beat_in,
  input  logic [DATA_WIDTH-1:0] external_counter,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TUSER,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  edge_count,
  output logic [CNT_WIDTH-1:0]  glitch_count
);
  typedef enum logic [1:0] {SETTLE, STABLE, BLANK} state_t;
  localparam logic [7:0] LEN = 8'(DEGLITCH_LEN);
  state_t state_q, state_d;
  logic level_q, level_d, run_q, run_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] ts_q, ts_d, tdata_q, tdata_d;
  logic tuser_q, tuser_d, tvalid_q, tvalid_d, ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] edge_q, edge_d, glitch_q, glitch_d;
  logic done, emit, glitch, hs, load;
  // run_q/cnt_q track the current run of equal samples, whichever level it is at
  assign cnt_inc = (beat_in == run_q) ? cnt_q + 8'd1 : 8'd1;
  assign done = cnt_inc == LEN;
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    run_d = beat_in;
    cnt_d = cnt_inc;
    ts_d = ts_q;
    emit = 1'b0;
    glitch = 1'b0;
    if (!enable_sampling_logic) begin
      state_d = SETTLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        SETTLE: if (done) begin
          level_d = beat_in;
          state_d = STABLE;
        end
        STABLE: begin
          cnt_d = 8'd1;
          if (beat_in != level_q) begin
            ts_d = external_counter;
            state_d = BLANK;
          end
        end
        BLANK: if (done) begin
          state_d = STABLE;
          emit = beat_in != level_q;
          glitch = beat_in == level_q;
          level_d = beat_in;
        end
        default: state_d = SETTLE;
      endcase
    end
  end
  assign hs = tvalid_q & M_AXIS_TREADY;
  assign load = emit & (~tvalid_q | M_AXIS_TREADY);
  assign tvalid_d = load | (tvalid_q & ~hs);
  assign tdata_d = load ? ts_q : tdata_q;
  assign tuser_d = load ? beat_in : tuser_q;
  assign ovf_d = ovf_q | (emit & ~load);
  assign edge_d = edge_q + CNT_WIDTH'(emit);
  assign glitch_d = glitch_q + CNT_WIDTH'(glitch);
  always_ff @(posedge clk_ref or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= SETTLE;
      level_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
      ts_q <= '0;
      tdata_q <= '0;
      tuser_q <= 1'b0;
      tvalid_q <= 1'b0;
      ovf_q <= 1'b0;
      edge_q <= '0;
      glitch_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      ts_q <= ts_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      tvalid_q <= tvalid_d;
      ovf_q <= ovf_d;
      edge_q <= edge_d;
      glitch_q <= glitch_d;
    end
  end
  assign M_AXIS_TDATA = tdata_q;
  assign M_AXIS_TUSER = tuser_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign overflow = ovf_q;
  assign edge_count = edge_q;
  assign glitch_count = glitch_q;
endmodule

// File: tb/tb_ddmtd_edge_tagger.sv
// tb_ddmtd_edge_tagger: directed vector table plus randomized run checked against a
// sample-history reference model of the edge tagger.
module tb_ddmtd_edge_tagger;
  localparam int L = 4;
  logic clk = 1'b0, rst_n, enable, beat, rdy;
  logic [31:0] ext;
  logic [31:0] tdata;
  logic tuser, tvalid, ovf;
  logic [15:0] ecnt, gcnt;
  int total = 0, bad = 0, cyc = 0;
  ddmtd_edge_tagger #(.DATA_WIDTH(32), .DEGLITCH_LEN(L), .CNT_WIDTH(16)) dut (
    .clk_ref(clk), .RESETN(rst_n), .enable_sampling_logic(enable), .beat_in(beat),
    .external_counter(ext), .M_AXIS_TDATA(tdata), .M_AXIS_TUSER(tuser),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(rdy), .overflow(ovf),
    .edge_count(ecnt), .glitch_count(gcnt)
  );
  always #5 clk = ~clk;
  // reference model: mode 0 settle, 1 stable, 2 blank; mq holds samples since the mode began
  int ms;
  bit ml, mv, mu, mo;
  bit mq[$];
  logic [31:0] mts, md;
  logic [15:0] me, mg;
  function automatic void model_reset();
    ms = 0; ml = 0; mv = 0; mu = 0; mo = 0; mts = 0; md = 0; me = 0; mg = 0;
    mq.delete();
  endfunction
  function automatic bit all_last(bit x);
    if (mq.size() < L) return 0;
    for (int i = mq.size() - L; i < mq.size(); i++) if (mq[i] != x) return 0;
    return 1;
  endfunction
  function automatic void model_step(bit en, bit b, bit r, logic [31:0] x);
    bit emit = 0;
    bit hs = mv && r;
    if (!en) begin
      ms = 0; mq.delete();
    end else if (ms == 0) begin
      mq.push_back(b);
      if (mq.size() > L) void'(mq.pop_front());
      if (all_last(b)) begin ml = b; ms = 1; mq.delete(); end
    end else if (ms == 1) begin
      if (b != ml) begin mts = x; mq.delete(); mq.push_back(b); ms = 2; end
    end else begin
      mq.push_back(b);
      if (mq.size() > L) void'(mq.pop_front());
      if (all_last(!ml)) begin emit = 1; ml = !ml; ms = 1; mq.delete(); end
      else if (all_last(ml)) begin mg++; ms = 1; mq.delete(); end
    end
    if (emit) begin
      me++;
      if (!mv || r) begin mv = 1; md = mts; mu = ml; end
      else mo = 1;
    end else if (hs) mv = 0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input bit en, input bit b, input bit r, input logic [31:0] x);
    enable = en; beat = b; rdy = r; ext = x;
    @(posedge clk);
    model_step(en, b, r, x);
    #1;
    chk("m_tvalid", tvalid, mv);
    if (mv) begin
      chk("m_tdata", tdata, md);
      chk("m_tuser", tuser, mu);
    end
    chk("m_overflow", ovf, mo);
    chk("m_edges", ecnt, me);
    chk("m_glitches", gcnt, mg);
    cyc++;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tuser"}, tuser, 0);
    chk({tag, "_overflow"}, ovf, 0);
    chk({tag, "_edges"}, ecnt, 0);
    chk({tag, "_glitches"}, gcnt, 0);
  endtask
  typedef struct {
    int n; bit en, b, r, v; logic [31:0] d; bit u, o; int e, g;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(int n, bit en, bit b, bit r, bit v, int d, bit u, bit o, int e, int g);
    vec_t t;
    t.n = n; t.en = en; t.b = b; t.r = r; t.v = v; t.d = 32'(d); t.u = u; t.o = o; t.e = e; t.g = g;
    tbl.push_back(t);
  endfunction
  initial begin
    int rb, run, dis, stall;
    //   n en b r  v  d  u o  e g
    add(20, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add( 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add( 1, 1, 1, 1, 1, 20, 1, 0, 1, 0);
    add( 1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    add( 5, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    add( 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add( 1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    add( 3, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add( 1, 1, 0, 1, 1, 30, 0, 0, 2, 0);
    add( 1, 1, 0, 1, 0, 0, 0, 0, 2, 0);
    add( 3, 1, 0, 1, 0, 0, 0, 0, 2, 0);
    add( 3, 1, 1, 1, 0, 0, 0, 0, 2, 0);
    add( 1, 1, 1, 1, 1, 40, 1, 0, 3, 0);
    add( 1, 1, 1, 1, 0, 0, 0, 0, 3, 0);
    add( 2, 1, 0, 1, 0, 0, 0, 0, 3, 0);
    add( 3, 1, 1, 1, 0, 0, 0, 0, 3, 0);
    add( 1, 1, 1, 1, 0, 0, 0, 0, 3, 1);
    add( 3, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    add( 1, 1, 0, 0, 1, 51, 0, 0, 4, 1);
    add( 3, 1, 0, 0, 1, 51, 0, 0, 4, 1);
    add( 3, 1, 1, 0, 1, 51, 0, 0, 4, 1);
    add( 1, 1, 1, 1, 1, 58, 1, 0, 5, 1);
    add( 1, 1, 1, 1, 0, 0, 0, 0, 5, 1);
    add( 3, 1, 0, 0, 0, 0, 0, 0, 5, 1);
    add( 1, 1, 0, 0, 1, 63, 0, 0, 6, 1);
    add( 3, 1, 0, 0, 1, 63, 0, 0, 6, 1);
    add( 3, 1, 1, 0, 1, 63, 0, 0, 6, 1);
    add( 1, 1, 1, 0, 1, 63, 0, 1, 7, 1);
    add( 1, 1, 1, 1, 0, 0, 0, 1, 7, 1);
    add( 2, 1, 0, 1, 0, 0, 0, 1, 7, 1);
    add( 1, 0, 0, 1, 0, 0, 0, 1, 7, 1);
    add( 3, 1, 0, 1, 0, 0, 0, 1, 7, 1);
    add( 6, 1, 1, 1, 0, 0, 0, 1, 7, 1);
    add( 3, 1, 0, 1, 0, 0, 0, 1, 7, 1);
    add( 1, 1, 0, 1, 1, 87, 0, 1, 8, 1);
    rst_n = 0; enable = 0; beat = 0; rdy = 0; ext = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1;
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) step(tbl[k].en, tbl[k].b, tbl[k].r, 32'(cyc));
      chk($sformatf("row%0d_tvalid", k), tvalid, tbl[k].v);
      if (tbl[k].v) begin
        chk($sformatf("row%0d_tdata", k), tdata, tbl[k].d);
        chk($sformatf("row%0d_tuser", k), tuser, tbl[k].u);
      end
      chk($sformatf("row%0d_overflow", k), ovf, tbl[k].o);
      chk($sformatf("row%0d_edges", k), ecnt, tbl[k].e);
      chk($sformatf("row%0d_glitches", k), gcnt, tbl[k].g);
    end
    // async reset while a word is pending must clear everything without a clock edge
    #2 rst_n = 0;
    #1 chk_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    cyc = 0; rb = 0; run = 0; dis = 0; stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        rb = 1 - rb;
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
      end
      run--;
      if (dis > 0) dis--;
      else if ($urandom_range(0, 299) == 0) dis = $urandom_range(1, 6);
      if (stall > 0) stall--;
      else if ($urandom_range(0, 19) == 0) stall = $urandom_range(1, 30);
      step(dis == 0, rb[0], stall == 0 && $urandom_range(0, 3) != 0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
